// File: rtl/eth_tx_arbiter.sv
`timescale 1ns/1ps
// eth_tx_arbiter: round-robin whole-frame arbiter sharing one RMII TX pair among R framers; optional per-source stats when TX_ARB_STATS_EN is defined.
// Latency: grant appears 1 cycle after a request is seen in IDLE; eth_txen/eth_txd lag the granted source beat by exactly 1 cycle.
// Backpressure: none on beats; sources hold src_req until granted, are revoked after START_TIMEOUT beats without valid, and frames are cut at MAX_BEATS.
module eth_tx_arbiter #(
    parameter int N             = 2,
    parameter int R             = 2,
    parameter int IFG_CYCLES    = 48,
    parameter int START_TIMEOUT = 16,
    parameter int MAX_BEATS     = 6120
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   src_req,
    input  logic [R-1:0]   src_valid,
    input  logic [R-1:0]   src_last,
    input  logic [R*N-1:0] src_data,
    output logic [R-1:0]   src_grant,
    output logic           eth_txen,
    output logic [N-1:0]   eth_txd,
    output logic           busy,
    output logic           underrun,
    output logic           truncated
`ifdef TX_ARB_STATS_EN
    ,
    output logic [R*16-1:0] frame_count,
    output logic [R*8-1:0]  err_count
`endif
);

    localparam int PW = (R > 1) ? $clog2(R) : 1;
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam int TW = $clog2(((IFG_CYCLES > START_TIMEOUT) ? IFG_CYCLES : START_TIMEOUT) + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] cur;
    logic [PW-1:0] win;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] idx;
    logic [BW-1:0] beat_cnt;
    logic [TW-1:0] tmr;

    logic          in_frame;
    logic          cur_valid;
    logic          cur_last;
    logic          cur_req;
    logic [N-1:0]  cur_data;
    logic          beat_ok;
    logic          at_max;
    logic          frame_done;
    logic          trunc_hit;
    logic          underrun_ev;
    logic          timeout_ev;
    logic          giveup_ev;

    assign in_frame    = (state == S_WAIT) || (state == S_SEND);
    assign cur_valid   = src_valid[cur];
    assign cur_last    = src_last[cur];
    assign cur_req     = src_req[cur];
    assign cur_data    = src_data[cur*N +: N];
    assign beat_ok     = in_frame && cur_valid;
    assign at_max      = (beat_cnt == BW'(MAX_BEATS - 1));
    assign frame_done  = beat_ok && (cur_last || at_max);
    assign trunc_hit   = beat_ok && !cur_last && at_max;
    assign underrun_ev = (state == S_SEND) && !cur_valid;
    assign timeout_ev  = (state == S_WAIT) && !cur_valid && cur_req && (tmr == TW'(START_TIMEOUT - 1));
    assign giveup_ev   = (state == S_WAIT) && !cur_valid && !cur_req;
    assign busy        = (state != S_IDLE);

    // Round-robin pick: first requester at or above ptr, wrapping modulo R.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = R - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % R);
            if (src_req[idx]) begin
                win = idx;
            end
        end
        ptr_nxt = (win == PW'(R - 1)) ? '0 : win + 1'b1;
    end

    // Grant is decoded from state so it falls together with an async reset.
    always_comb begin
        src_grant = '0;
        if (in_frame) begin
            src_grant[cur] = 1'b1;
        end
    end

    // Frame FSM: arbitration, beat forwarding, timeout, truncation and gap timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cur       <= '0;
            beat_cnt  <= '0;
            tmr       <= '0;
            eth_txen  <= 1'b0;
            eth_txd   <= '0;
            underrun  <= 1'b0;
            truncated <= 1'b0;
        end else begin
            eth_txen  <= 1'b0;
            eth_txd   <= '0;
            underrun  <= 1'b0;
            truncated <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|src_req) begin
                        cur      <= win;
                        ptr      <= ptr_nxt;
                        tmr      <= '0;
                        beat_cnt <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT, S_SEND: begin
                    if (beat_ok) begin
                        eth_txen <= 1'b1;
                        eth_txd  <= cur_data;
                        if (frame_done) begin
                            truncated <= trunc_hit;
                            tmr       <= '0;
                            state     <= S_GAP;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            state    <= S_SEND;
                        end
                    end else if (state == S_SEND) begin
                        // Last txen-high cycle was the previous one, so this cycle already counts as gap.
                        underrun <= 1'b1;
                        tmr      <= TW'(1);
                        state    <= S_GAP;
                    end else if (giveup_ev || timeout_ev) begin
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_GAP: begin
                    if (tmr == TW'(IFG_CYCLES)) begin
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef TX_ARB_STATS_EN
    logic [15:0] fc [R];
    logic [7:0]  ec [R];

    // Saturating per-source completed-frame and error counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < R; i++) begin
                fc[i] <= '0;
                ec[i] <= '0;
            end
        end else begin
            if (frame_done && (fc[cur] != '1)) begin
                fc[cur] <= fc[cur] + 1'b1;
            end
            if ((underrun_ev || timeout_ev) && (ec[cur] != '1)) begin
                ec[cur] <= ec[cur] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < R; g++) begin : g_stats
        assign frame_count[g*16 +: 16] = fc[g];
        assign err_count[g*8 +: 8]     = ec[g];
    end
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
`timescale 1ns/1ps
// tb_eth_tx_arbiter: directed bench with a beat scoreboard on the RMII pins.
// Latency: expects pins one cycle behind the granted source.
// Backpressure: sources wait for grant; all waits are cycle-bounded.
module tb_eth_tx_arbiter;

    localparam int R    = 2;
    localparam int NB   = 2;
    localparam int MAXB = 20;
    localparam int IFG  = 48;
    localparam int TMO  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [R-1:0]    src_req   = '0;
    logic [R-1:0]    src_valid = '0;
    logic [R-1:0]    src_last  = '0;
    logic [R*NB-1:0] src_data  = '0;
    logic [R-1:0]    src_grant;
    logic            eth_txen;
    logic [NB-1:0]   eth_txd;
    logic            busy;
    logic            underrun;
    logic            truncated;
`ifdef TX_ARB_STATS_EN
    logic [R*16-1:0] frame_count;
    logic [R*8-1:0]  err_count;
`endif

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [NB-1:0] q[$];
    int            txen_run = 0;
    int            idle_run = 0;
    int            last_run = 0;
    int            last_gap = 0;
    int            und_cnt  = 0;
    int            trn_cnt  = 0;
    int            mptr     = 0;
    int            exp_frames[R];
    int            exp_err[R];

    eth_tx_arbiter #(
        .N(NB), .R(R), .IFG_CYCLES(IFG), .START_TIMEOUT(TMO), .MAX_BEATS(MAXB)
    ) dut (
        .clk(clk), .rst(rst),
        .src_req(src_req), .src_valid(src_valid), .src_last(src_last), .src_data(src_data),
        .src_grant(src_grant), .eth_txen(eth_txen), .eth_txd(eth_txd),
        .busy(busy), .underrun(underrun), .truncated(truncated)
`ifdef TX_ARB_STATS_EN
        , .frame_count(frame_count), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pin monitor: scoreboard pops, grant one-hot, run/gap lengths, pulse counts.
    always @(negedge clk) begin
        if (!rst) begin
            txen_run = 0;
            idle_run = 0;
        end else begin
            chk("grant_onehot", 32'($onehot0(src_grant)), 32'd1);
            if (eth_txen) begin
                if (q.size() == 0) chk("txd_unexpected_beat", 32'd1, 32'd0);
                else chk("txd", 32'(eth_txd), 32'(q.pop_front()));
                txen_run++;
                idle_run = 0;
            end else begin
                if (txen_run != 0) last_run = txen_run;
                txen_run = 0;
                chk("txd_idle", 32'(eth_txd), 32'd0);
                if (busy) idle_run++;
            end
            if (!busy) begin
                if (idle_run != 0) last_gap = idle_run;
                idle_run = 0;
            end
            if (underrun) und_cnt++;
            if (truncated) trn_cnt++;
        end
    end

    task automatic wait_grant(input int s);
        int k;
        k = 0;
        while (src_grant == '0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (src_grant == '0) chk("grant_wait_expired", 32'd0, 32'd1);
        else chk("grant_owner", 32'(src_grant), 32'(1 << s));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_wait_expired", 32'd0, 32'd1);
        #1;
    endtask

    task automatic stream(input int s, input int n, input bit use_last, input int stop_at);
        logic [NB-1:0] d;
        for (int i = 0; i < n; i++) begin
            if (i == stop_at) break;
            d = NB'($urandom_range(0, 3));
            src_valid[s] = 1'b1;
            src_data[s*NB +: NB] = d;
            src_last[s] = use_last && (i == n - 1);
            if (i < MAXB) q.push_back(d);
            @(negedge clk);
            if (i == 0 && n > 1) chk("txen_lag1", 32'(eth_txen), 32'd1);
        end
        src_valid[s] = 1'b0;
        src_last[s]  = 1'b0;
    endtask

    initial begin
        int s, gc, t0;
        logic [NB-1:0] d;
        for (int i = 0; i < R; i++) begin
            exp_frames[i] = 0;
            exp_err[i]    = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(src_grant), 32'd0);
        chk("rst_txen", 32'(eth_txen), 32'd0);
        chk("rst_txd", 32'(eth_txd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_truncated", 32'(truncated), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: single 10-beat frame from src0
        src_req[0] = 1'b1;
        @(negedge clk);
        chk("t1_grant_next_cycle", 32'(src_grant), 32'd1);
        src_req[0] = 1'b0;
        mptr = 1;
        stream(0, 10, 1'b1, -1);
        wait_idle();
        exp_frames[0]++;
        chk("t1_txen_cycles", last_run, 10);
        chk("t1_gap", last_gap, IFG);
        chk("t1_underrun_cnt", und_cnt, 0);
        chk("t1_truncated_cnt", trn_cnt, 0);

        // 2: both requesting, alternating service
        src_req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            s = mptr;
            wait_grant(s);
            mptr = (s + 1) % R;
            if (f == 3) src_req = 2'b00;
            stream(s, 8, 1'b1, -1);
            wait_idle();
            exp_frames[s]++;
            chk("t2_txen_cycles", last_run, 8);
            chk("t2_gap", last_gap, IFG);
        end

        // 3: src1 underrun after beat 5, then src0 served
        src_req[1] = 1'b1;
        wait_grant(1);
        src_req[1] = 1'b0;
        mptr = 0;
        src_req[0] = 1'b1;
        stream(1, 10, 1'b1, 6);
        @(negedge clk);
        chk("t3_underrun_pulse", 32'(underrun), 32'd1);
        chk("t3_txen_low", 32'(eth_txen), 32'd0);
        @(negedge clk);
        chk("t3_underrun_1cycle", 32'(underrun), 32'd0);
        exp_err[1]++;
        wait_idle();
        chk("t3_txen_cycles", last_run, 6);
        chk("t3_gap", last_gap, IFG);
        wait_grant(0);
        src_req[0] = 1'b0;
        mptr = 1;
        stream(0, 5, 1'b1, -1);
        wait_idle();
        exp_frames[0]++;
        chk("t3_src0_txen_cycles", last_run, 5);
        chk("t3_underrun_cnt", und_cnt, 1);
`ifdef TX_ARB_STATS_EN
        chk("t3_err_count1", 32'(err_count[15:8]), 32'(exp_err[1]));
`endif

        // 4: start timeout, pending src1 granted right after
        src_req[0] = 1'b1;
        wait_grant(0);
        mptr = 1;
        src_req[1] = 1'b1;
        gc = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (src_grant[0]) gc++;
            else break;
        end
        chk("t4_grant_cycles", gc, TMO);
        chk("t4_no_gap_busy", 32'(busy), 32'd0);
        src_req[0] = 1'b0;
        exp_err[0]++;
        @(negedge clk);
        chk("t4_src1_next_cycle", 32'(src_grant), 32'd2);
        mptr = 0;
        src_req[1] = 1'b0;
        stream(1, 3, 1'b1, -1);
        wait_idle();
        exp_frames[1]++;
        chk("t4_txen_cycles", last_run, 3);

        // 5: truncation at MAX_BEATS, then last exactly on MAX_BEATS
        src_req[0] = 1'b1;
        wait_grant(0);
        src_req[0] = 1'b0;
        mptr = 1;
        t0 = trn_cnt;
        stream(0, 30, 1'b1, -1);
        wait_idle();
        exp_frames[0]++;
        chk("t5_trunc_txen_cycles", last_run, MAXB);
        chk("t5_trunc_pulse", trn_cnt - t0, 1);
        chk("t5_trunc_gap", last_gap, IFG);
        src_req[0] = 1'b1;
        wait_grant(0);
        src_req[0] = 1'b0;
        t0 = trn_cnt;
        stream(0, MAXB, 1'b1, -1);
        wait_idle();
        exp_frames[0]++;
        chk("t5_full_txen_cycles", last_run, MAXB);
        chk("t5_full_no_trunc", trn_cnt - t0, 0);
`ifdef TX_ARB_STATS_EN
        for (int i = 0; i < R; i++) begin
            chk("stats_frames", 32'(frame_count[i*16 +: 16]), 32'(exp_frames[i]));
            chk("stats_errs", 32'(err_count[i*8 +: 8]), 32'(exp_err[i]));
        end
`endif

        // 6: reset during beat 7 of a src0 frame
        src_req[0] = 1'b1;
        wait_grant(0);
        src_req[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d = NB'($urandom_range(0, 3));
            src_valid[0] = 1'b1;
            src_data[NB-1:0] = d;
            if (i < 7) begin
                q.push_back(d);
                @(negedge clk);
            end
        end
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_txen", 32'(eth_txen), 32'd0);
        chk("t6_rst_grant", 32'(src_grant), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        src_valid = '0;
        q.delete();
        for (int i = 0; i < R; i++) begin
            exp_frames[i] = 0;
            exp_err[i]    = 0;
        end
        @(negedge clk);
        src_req = 2'b11;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_ptr_reset_src0_first", 32'(src_grant), 32'd1);
        mptr = 1;
        src_req[0] = 1'b0;
        stream(0, 4, 1'b1, -1);
        wait_idle();
        exp_frames[0]++;
        chk("t6_src0_txen_cycles", last_run, 4);
        wait_grant(1);
        src_req[1] = 1'b0;
        mptr = 0;
        stream(1, 4, 1'b1, -1);
        wait_idle();
        exp_frames[1]++;
        chk("t6_src1_txen_cycles", last_run, 4);
        chk("t6_gap", last_gap, IFG);
`ifdef TX_ARB_STATS_EN
        for (int i = 0; i < R; i++) begin
            chk("t6_stats_frames", 32'(frame_count[i*16 +: 16]), 32'(exp_frames[i]));
            chk("t6_stats_errs", 32'(err_count[i*8 +: 8]), 32'(exp_err[i]));
        end
`endif
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
